// File: rtl/edge_freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Results register on the GATE->DONE edge with a one-cycle valid strobe; start ignored while busy.
module edge_freq_meter #(
  parameter int GATE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             edge_det;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_int_q, ovf_int_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  // Edge detector runs in every state so a level settled before a window is never an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~prev_q;

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = GATE;
          gate_d    = GATE_LOAD;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end
      end
      GATE: begin
        gate_d = gate_q - GW'(1);
        if (edge_det) begin
          if (cnt_q == CNT_MAX) ovf_int_d = 1'b1;
          else                  cnt_d     = cnt_q + CNT_W'(1);
        end
        // Publish the next-state totals so the final cycle's edge is included.
        if (gate_q == '0) begin
          state_d = DONE;
          count_d = cnt_d;
          ovf_d   = ovf_int_d;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (cont) begin
          state_d   = GATE;
          gate_d    = GATE_LOAD;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_edge_freq_meter.sv
// Directed bench: two meters (CNT_W=8 and CNT_W=2) share stimulus; sig_in is
// either a held level or toggled every clock on the falling edge.
module tb_edge_freq_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       tog_en = 1'b0;
  logic       sig_lvl = 1'b0;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic       valid_a, ovf_a, busy_a;
  logic       valid_b, ovf_b, busy_b;

  int tests = 0;
  int failed = 0;
  int vld_at, busy_cyc, vld_cnt;

  always #5 clk = ~clk;

  always @(negedge clk) sig_in = tog_en ? ~sig_in : sig_lvl;

  edge_freq_meter #(.GATE_CYCLES(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .count(count_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
  );

  edge_freq_meter #(.GATE_CYCLES(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .count(count_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start once, then observes 40 cycles; a second start pulse may be
  // injected at step restart_at to confirm it is ignored while busy.
  task automatic run_window(input int restart_at, output int v_at, output int b_cyc, output int v_cnt);
    start = 1'b1;
    step();
    start = 1'b0;
    b_cyc = busy_a ? 1 : 0;
    v_at  = -1;
    v_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      start = (i == restart_at);
      step();
      if (busy_a) b_cyc++;
      if (valid_a) begin
        v_cnt++;
        if (v_at < 0) v_at = i;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int t, prev_t, nv, stray;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_count", 32'(count_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_ovf",   32'(ovf_a), 0);
    check("rst_busy",  32'(busy_a), 0);

    // Constant-low input
    repeat (4) step();
    run_window(-1, vld_at, busy_cyc, vld_cnt);
    check("zero_vld_at",  32'(vld_at), 16);
    check("zero_vld_cnt", 32'(vld_cnt), 1);
    check("zero_busy",    32'(busy_cyc), 17);
    check("zero_count",   32'(count_a), 0);
    check("zero_ovf",     32'(ovf_a), 0);

    // Period-2 input: 8 edges in 16 cycles, saturates the 2-bit meter
    tog_en = 1'b1;
    repeat (6) step();
    run_window(-1, vld_at, busy_cyc, vld_cnt);
    check("tog_vld_at", 32'(vld_at), 16);
    check("tog_count",  32'(count_a), 8);
    check("tog_ovf",    32'(ovf_a), 0);
    check("sat_count",  32'(count_b), 3);
    check("sat_ovf",    32'(ovf_b), 1);

    tog_en  = 1'b0;
    sig_lvl = 1'b0;
    repeat (6) step();
    run_window(-1, vld_at, busy_cyc, vld_cnt);
    check("clr_count_b", 32'(count_b), 0);
    check("clr_ovf_b",   32'(ovf_b), 0);
    check("clr_count_a", 32'(count_a), 0);

    // Continuous mode
    tog_en = 1'b1;
    repeat (6) step();
    cont  = 1'b1;
    start = 1'b1;
    step();
    start  = 1'b0;
    t      = 0;
    prev_t = -1;
    nv     = 0;
    while (nv < 3 && t < 200) begin
      step();
      t++;
      if (valid_a) begin
        nv++;
        check("cont_count", 32'(count_a), 8);
        if (prev_t >= 0) check("cont_period", 32'(t - prev_t), 17);
        prev_t = t;
      end
    end
    check("cont_nvalid", 32'(nv), 3);
    cont = 1'b0;
    step();
    check("cont_busy_off", 32'(busy_a), 0);
    check("cont_valid_off", 32'(valid_a), 0);

    // Reset in the middle of a window
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("abort_busy",  32'(busy_a), 0);
    check("abort_count", 32'(count_a), 0);
    check("abort_valid", 32'(valid_a), 0);
    check("abort_ovf_b", 32'(ovf_b), 0);
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid_a || busy_a) stray++;
    end
    check("abort_no_valid", 32'(stray), 0);
    run_window(-1, vld_at, busy_cyc, vld_cnt);
    check("abort_restart_at",    32'(vld_at), 16);
    check("abort_restart_count", 32'(count_a), 8);

    // Input held high across reset and window; extra start while busy
    tog_en  = 1'b0;
    sig_lvl = 1'b1;
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    run_window(5, vld_at, busy_cyc, vld_cnt);
    check("hold_count",   32'(count_a), 0);
    check("hold_vld_cnt", 32'(vld_cnt), 1);
    check("hold_vld_at",  32'(vld_at), 16);
    check("hold_count_b", 32'(count_b), 0);
    check("hold_ovf_b",   32'(ovf_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
